// File: rtl/round_word_seq_pkg.sv
// Shared types and constants for the round-word store/sequencer.
package rws_pkg;
  typedef enum logic [1:0] {IDLE, READY, RUN} state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 15;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
endpackage

// File: rtl/round_word_seq_mux.sv
// word_mux_n: combinational DEPTH:1 word select; an index beyond DEPTH-1 yields zero.
module word_mux_n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 15,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] words,
  input  logic [SEL_W-1:0]            idx,
  output logic [WIDTH-1:0]            word
);
  logic [DEPTH-1:0][WIDTH-1:0] masked;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mask
      assign masked[gi] = (idx == SEL_W'(gi)) ? words[gi] : '0;
    end
  endgenerate

  // At most one lane is non-zero, so an OR-reduce is the select.
  always_comb begin
    word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word = word | masked[i];
    end
  end
endmodule

// File: rtl/round_word_seq.sv
// round_word_seq: loads DEPTH round words, then streams NUM+1 of them forward or reverse on NEXT.
// Optional direct word read in READY is enabled by defining DIRECT_SEL_EN.
module round_word_seq
  import rws_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             start,
  input  logic             dir,
  input  logic [SEL_W-1:0] num,
  input  logic             next,
`ifdef DIRECT_SEL_EN
  input  logic             rd_en,
  input  logic [SEL_W-1:0] sel,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             done,
  output logic             busy,
  output logic             err
);
  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   wptr_reg, wptr_next;
  logic [SEL_W-1:0]   idx_reg, idx_next;
  logic [SEL_W-1:0]   num_reg, num_next;
  logic               dir_reg, dir_next;
  logic [WIDTH-1:0]   dout_reg, dout_next;
  logic               dvalid_reg, dvalid_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               mem_we;

  logic [WIDTH-1:0]            mem [DEPTH];
  logic [DEPTH-1:0][WIDTH-1:0] mem_flat;
  logic [SEL_W-1:0]            mux_idx;
  logic [WIDTH-1:0]            mux_word;
  logic                        num_ok;
  logic [SEL_W-1:0]            end_idx;

  // Word storage has no reset; contents survive clr.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_reg] <= wr_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign mem_flat[gi] = mem[gi];
    end
  endgenerate

`ifdef DIRECT_SEL_EN
  logic sel_ok;
  assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(DEPTH));
  assign mux_idx = (state_reg == READY) ? sel : idx_reg;
`else
  assign mux_idx = idx_reg;
`endif

  word_mux_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_mux (
    .words (mem_flat),
    .idx   (mux_idx),
    .word  (mux_word)
  );

  assign num_ok  = ({1'b0, num} < (SEL_W+1)'(DEPTH));
  assign end_idx = (dir_reg == DIR_FWD) ? num_reg : '0;

  always_comb begin
    state_next  = state_reg;
    wptr_next   = wptr_reg;
    idx_next    = idx_reg;
    num_next    = num_reg;
    dir_next    = dir_reg;
    dout_next   = dout_reg;
    dvalid_next = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    mem_we      = 1'b0;

    if (clr) begin
      state_next = IDLE;
      wptr_next  = '0;
    end else begin
      if (wr_en) begin
        if (state_reg == IDLE) begin
          mem_we = 1'b1;
          if (wptr_reg == SEL_W'(DEPTH - 1)) begin
            state_next = READY;
          end else begin
            wptr_next = wptr_reg + 1'b1;
          end
        end else begin
          err_next = 1'b1;
        end
      end

      if (start && state_reg == READY && num_ok) begin
        // An accepted START swallows NEXT (and direct reads) in the same cycle.
        state_next = RUN;
        dir_next   = dir;
        num_next   = num;
        idx_next   = (dir == DIR_REV) ? num : '0;
      end else begin
        if (start) err_next = 1'b1;
        if (next && state_reg == RUN) begin
          dout_next   = mux_word;
          dvalid_next = 1'b1;
          if (idx_reg == end_idx) begin
            done_next  = 1'b1;
            state_next = READY;
          end else if (dir_reg == DIR_REV) begin
            idx_next = idx_reg - 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
`ifdef DIRECT_SEL_EN
        if (rd_en && !start) begin
          if (state_reg == READY) begin
            dout_next   = mux_word;
            dvalid_next = 1'b1;
            if (!sel_ok) err_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wptr_reg   <= '0;
      idx_reg    <= '0;
      num_reg    <= '0;
      dir_reg    <= 1'b0;
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wptr_reg   <= wptr_next;
      idx_reg    <= idx_next;
      num_reg    <= num_next;
      dir_reg    <= dir_next;
      dout_reg   <= dout_next;
      dvalid_reg <= dvalid_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign dout   = dout_reg;
  assign dvalid = dvalid_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign busy   = (state_reg == RUN);
  assign full   = (state_reg != IDLE);
endmodule
